// File: rtl/branch_predict_ctrl.sv
// Branch prediction / resolution controller for the RV32I 5-stage pipe.
// F stage: combinational lookup of a direct-mapped BTB/BHT indexed by PCF.
// E stage: compares the carried prediction against the resolved outcome,
// raises mispredict/flush/redirect and trains the tables at the clock edge.
// Optional: define BP_STATS_EN to add branch/mispredict counters as outputs.

// One BTB/BHT entry. Only valid and ctr are reset; tag/target/isJump are
// qualified by valid, so they are left unreset.
module branch_predict_entry #(
    parameter int TAGW = 26
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic            wvalid,
    input  logic [TAGW-1:0] wtag,
    input  logic [31:0]     wtarget,
    input  logic            wjump,
    input  logic [1:0]      wctr,
    output logic            valid,
    output logic [TAGW-1:0] tag,
    output logic [31:0]     target,
    output logic            isjump,
    output logic [1:0]      ctr
);

    // Valid bit and counter: cleared to weakly-not-taken on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            ctr   <= 2'b01;
        end else if (we) begin
            valid <= wvalid;
            ctr   <= wctr;
        end
    end

    // Payload fields, don't-care until the entry is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            tag    <= wtag;
            target <= wtarget;
            isjump <= wjump;
        end
    end

endmodule

module branch_predict_ctrl #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic        predTakenF,
    output logic [31:0] nextPCF,
    input  logic        validE,
    input  logic        branchE,
    input  logic        jumpE,
    input  logic        branchTakenE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] PCTargetE,
    input  logic        predTakenE,
    input  logic [31:0] predTargetE,
    output logic        mispredictE,
    output logic [31:0] redirectPCE,
    output logic        flushD,
    output logic        flushE
`ifdef BP_STATS_EN
    ,
    output logic [31:0] statBranches,
    output logic [31:0] statMispredicts
`endif
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDXW;

    logic [ENTRIES-1:0]           e_valid;
    logic [ENTRIES-1:0][TAGW-1:0] e_tag;
    logic [ENTRIES-1:0][31:0]     e_target;
    logic [ENTRIES-1:0]           e_jump;
    logic [ENTRIES-1:0][1:0]      e_ctr;

    logic            wr_en;
    logic            wr_valid;
    logic [TAGW-1:0] wr_tag;
    logic [31:0]     wr_target;
    logic            wr_jump;
    logic [1:0]      wr_ctr;

    logic [IDXW-1:0] idx_f, idx_e;
    logic [TAGW-1:0] tag_f, tag_e;
    logic            hit_f, tagm_e, hit_e;
    logic            actt, ctl;
    logic [1:0]      cur_ctr;

    // Byte-offset bits never participate in index or tag.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

    assign idx_f = PCF[IDXW+1:2];
    assign tag_f = PCF[31:IDXW+2];
    assign idx_e = PCE[IDXW+1:2];
    assign tag_e = PCE[31:IDXW+2];

    // F-stage lookup; reads the table before any same-edge E-stage write.
    always_comb begin
        hit_f      = e_valid[idx_f] && (e_tag[idx_f] == tag_f);
        predTakenF = hit_f && (e_jump[idx_f] || e_ctr[idx_f][1]);
        nextPCF    = predTakenF ? e_target[idx_f] : PCF + 32'd4;
    end

    // E-stage resolution: mispredict on wrong direction, wrong target for a
    // taken control transfer, or a taken prediction on a non-control instr.
    always_comb begin
        actt = jumpE || (branchE && branchTakenE);
        ctl  = branchE || jumpE;
        mispredictE = validE && (
            (ctl && (actt != predTakenE)) ||
            (ctl && actt && predTakenE && (predTargetE != PCTargetE)) ||
            (!ctl && predTakenE));
        redirectPCE = actt ? PCTargetE : PCPlus4E;
        flushD      = mispredictE;
        flushE      = mispredictE;
    end

    // Training write for the entry at PCE's index.
    always_comb begin
        tagm_e    = (e_tag[idx_e] == tag_e);
        hit_e     = e_valid[idx_e] && tagm_e;
        cur_ctr   = e_ctr[idx_e];
        wr_en     = 1'b0;
        wr_valid  = 1'b1;
        wr_tag    = tag_e;
        wr_target = PCTargetE;
        wr_jump   = jumpE;
        wr_ctr    = 2'b10;
        if (validE) begin
            if (ctl) begin
                if (hit_e) begin
                    wr_en     = 1'b1;
                    wr_target = actt ? PCTargetE : e_target[idx_e];
                    if (actt)
                        wr_ctr = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'b01;
                    else
                        wr_ctr = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'b01;
                end else if (actt) begin
                    wr_en = 1'b1;
                end
            end else if (predTakenE && tagm_e) begin
                // Aliased prediction on a non-branch: drop the entry.
                wr_en     = 1'b1;
                wr_valid  = 1'b0;
                wr_target = e_target[idx_e];
                wr_jump   = e_jump[idx_e];
                wr_ctr    = cur_ctr;
            end
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        branch_predict_entry #(.TAGW(TAGW)) u_ent (
            .clk     (clk),
            .reset   (reset),
            .we      (wr_en && (idx_e == IDXW'(g))),
            .wvalid  (wr_valid),
            .wtag    (wr_tag),
            .wtarget (wr_target),
            .wjump   (wr_jump),
            .wctr    (wr_ctr),
            .valid   (e_valid[g]),
            .tag     (e_tag[g]),
            .target  (e_target[g]),
            .isjump  (e_jump[g]),
            .ctr     (e_ctr[g])
        );
    end

`ifdef BP_STATS_EN
    // Free-running event counters, wrap at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            statBranches    <= '0;
            statMispredicts <= '0;
        end else begin
            if (validE && ctl)
                statBranches <= statBranches + 32'd1;
            if (mispredictE)
                statMispredicts <= statMispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: expected values are queued when
// stimulus is driven and popped when the outputs are sampled mid-cycle.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        predTakenF;
    logic [31:0] nextPCF;
    logic        validE, branchE, jumpE, branchTakenE;
    logic [31:0] PCE, PCPlus4E, PCTargetE;
    logic        predTakenE;
    logic [31:0] predTargetE;
    logic        mispredictE;
    logic [31:0] redirectPCE;
    logic        flushD, flushE;
`ifdef BP_STATS_EN
    logic [31:0] statBranches, statMispredicts;
`endif

    branch_predict_ctrl #(.ENTRIES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .PCF          (PCF),
        .predTakenF   (predTakenF),
        .nextPCF      (nextPCF),
        .validE       (validE),
        .branchE      (branchE),
        .jumpE        (jumpE),
        .branchTakenE (branchTakenE),
        .PCE          (PCE),
        .PCPlus4E     (PCPlus4E),
        .PCTargetE    (PCTargetE),
        .predTakenE   (predTakenE),
        .predTargetE  (predTargetE),
        .mispredictE  (mispredictE),
        .redirectPCE  (redirectPCE),
        .flushD       (flushD),
        .flushE       (flushE)
`ifdef BP_STATS_EN
        ,
        .statBranches    (statBranches),
        .statMispredicts (statMispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle_e();
        validE = 0; branchE = 0; jumpE = 0; branchTakenE = 0;
        PCE = 0; PCPlus4E = 4; PCTargetE = 0; predTakenE = 0; predTargetE = 0;
    endtask

    // F-stage lookup with E idle; inputs driven at negedge, sampled 2ns later.
    task automatic look(input logic [31:0] pc, input logic exp_pt,
                        input logic [31:0] exp_npc);
        idle_e();
        PCF = pc;
        push($sformatf("predTakenF@%0h", pc), {31'd0, exp_pt});
        push($sformatf("nextPCF@%0h", pc), exp_npc);
        #2;
        pop_chk({31'd0, predTakenF});
        pop_chk(nextPCF);
        @(negedge clk);
    endtask

    // E-stage resolution; PCF shadows PCE so the pre-update lookup is checked.
    task automatic resolve(input string nm, input logic v, input logic b,
                           input logic j, input logic tk,
                           input logic [31:0] pce, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt,
                           input logic exp_pf, input logic exp_m,
                           input logic [31:0] exp_r);
        validE = v; branchE = b; jumpE = j; branchTakenE = tk;
        PCE = pce; PCPlus4E = pce + 32'd4; PCTargetE = tgt;
        predTakenE = ptk; predTargetE = ptgt;
        PCF = pce;
        push({nm, ".predTakenF"}, {31'd0, exp_pf});
        push({nm, ".mispredictE"}, {31'd0, exp_m});
        push({nm, ".redirectPCE"}, exp_r);
        push({nm, ".flushD"}, {31'd0, exp_m});
        push({nm, ".flushE"}, {31'd0, exp_m});
        #2;
        pop_chk({31'd0, predTakenF});
        pop_chk({31'd0, mispredictE});
        pop_chk(redirectPCE);
        pop_chk({31'd0, flushD});
        pop_chk({31'd0, flushE});
        @(negedge clk);
        idle_e();
    endtask

    initial begin
        idle_e();
        PCF   = 32'h100;
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;

        // Post-reset state.
        resolve("rst", 0, 0, 0, 0, 32'h100, 32'h0, 0, 32'h0, 0, 0, 32'h104);
        look(32'h100, 0, 32'h104);
        look(32'hFFFF_FFFC, 0, 32'h0);
`ifdef BP_STATS_EN
        push("statBranches.rst", 0);    #2; pop_chk(statBranches);
        push("statMispredicts.rst", 0); pop_chk(statMispredicts);
        @(negedge clk);
`endif

        // beq 0x100 taken to 0x80, predicted not-taken; allocate.
        resolve("beq_alloc", 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104, 0, 1, 32'h80);
        look(32'h100, 1, 32'h80);

        // Three not-taken resolutions: ctr 10->01->00->00.
        resolve("nt1", 1, 1, 0, 0, 32'h100, 32'h80, 1, 32'h80, 1, 1, 32'h104);
        look(32'h100, 0, 32'h104);
        resolve("nt2", 1, 1, 0, 0, 32'h100, 32'h80, 0, 32'h104, 0, 0, 32'h104);
        resolve("nt3", 1, 1, 0, 0, 32'h100, 32'h80, 0, 32'h104, 0, 0, 32'h104);
        look(32'h100, 0, 32'h104);

        // Two taken resolutions: 00->01->10, predicts taken again.
        resolve("tk1", 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104, 0, 1, 32'h80);
        look(32'h100, 0, 32'h104);
        resolve("tk2", 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104, 0, 1, 32'h80);
        look(32'h100, 1, 32'h80);

        // jal 0x200 -> 0x400, then jalr-style retarget to 0x500.
        resolve("jal", 1, 0, 1, 0, 32'h200, 32'h400, 0, 32'h204, 0, 1, 32'h400);
        look(32'h200, 1, 32'h400);
        resolve("jalr", 1, 0, 1, 0, 32'h200, 32'h500, 1, 32'h400, 1, 1, 32'h500);
        look(32'h200, 1, 32'h500);
        resolve("jalr_ok", 1, 0, 1, 0, 32'h200, 32'h500, 1, 32'h500, 1, 0, 32'h500);

        // Aliased non-branch predicted taken: bubble first, then real.
        resolve("alias_v0", 0, 0, 0, 0, 32'h200, 32'h0, 1, 32'h500, 1, 0, 32'h204);
        look(32'h200, 1, 32'h500);
        resolve("alias_v1", 1, 0, 0, 0, 32'h200, 32'h0, 1, 32'h500, 1, 1, 32'h204);
        look(32'h200, 0, 32'h204);

        // 0x140 shares 0x100's index with a different tag: replaces it.
        resolve("conflict", 1, 1, 0, 1, 32'h140, 32'h300, 0, 32'h144, 0, 1, 32'h300);
        look(32'h140, 1, 32'h300);
        look(32'h100, 0, 32'h104);

`ifdef BP_STATS_EN
        push("statBranches", 10);   #2; pop_chk(statBranches);
        push("statMispredicts", 8); pop_chk(statMispredicts);
        @(negedge clk);
`endif

        // Reset mid-operation discards training.
        reset = 1;
        @(negedge clk);
        reset = 0;
        look(32'h140, 0, 32'h144);
        look(32'h200, 0, 32'h204);
`ifdef BP_STATS_EN
        push("statBranches.rst2", 0);    #2; pop_chk(statBranches);
        push("statMispredicts.rst2", 0); pop_chk(statMispredicts);
`endif

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
